lcd_phy: RTL and testbench

LCD_PHY -- requirements
Module: lcd_phy

---
 rtl/lcd_phy.sv | 111 +++++++++++
 tb/tb_lcd_phy.sv | 118 +++++++++++
 2 files changed

// File: rtl/lcd_phy.sv
// lcd_phy: HD44780 bus timing engine; runs one SETUP/E-high/HOLD cycle per
// accepted instruction, with phase lengths scaled by a latched tick prescaler.
module lcd_phy #(
    parameter int DATA_WIDTH      = 8,
    parameter int INSTR_WIDTH     = 10,
    parameter int PRESCALER_WIDTH = 16,
    parameter int SETUP_TICKS     = 1,
    parameter int EHIGH_TICKS     = 3,
    parameter int HOLD_TICKS      = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       phy_enable_i,
    input  logic [PRESCALER_WIDTH-1:0] prescaler_10ns_i,
    input  logic [INSTR_WIDTH-1:0]     lcd_instr_i,
    input  logic                       valid_instr_i,
    output logic                       phy_read_o,
    output logic [DATA_WIDTH-1:0]      lcd_rdata_o,
    output logic                       busy_o,
    output logic                       lcd_rs_o,
    output logic                       lcd_rw_o,
    output logic                       lcd_e_o,
    output logic [DATA_WIDTH-1:0]      lcd_db_o,
    output logic                       lcd_db_oe_o,
    input  logic [DATA_WIDTH-1:0]      lcd_db_i
);
    localparam int MAX_T = (SETUP_TICKS > EHIGH_TICKS) ?
        ((SETUP_TICKS > HOLD_TICKS) ? SETUP_TICKS : HOLD_TICKS) :
        ((EHIGH_TICKS > HOLD_TICKS) ? EHIGH_TICKS : HOLD_TICKS);
    localparam int PH_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int PW = PRESCALER_WIDTH;

    typedef enum logic [1:0] {IDLE, SETUP, EHIGH, HOLD} state_t;

    state_t                state_q;
    logic [PW-1:0]         tick_q, p_q, p_d;
    logic [PH_W-1:0]       phase_q, ph_last;
    logic                  tick_end, phase_end;
    logic                  read_q, busy_q, rs_q, rw_q, e_q, oe_q;
    logic [DATA_WIDTH-1:0] db_q, rdata_q;

    always_comb begin
        p_d       = (prescaler_10ns_i == '0) ? PW'(1) : prescaler_10ns_i;
        ph_last   = (state_q == SETUP) ? PH_W'(SETUP_TICKS - 1) :
                    (state_q == EHIGH) ? PH_W'(EHIGH_TICKS - 1) : PH_W'(HOLD_TICKS - 1);
        tick_end  = tick_q == p_q - PW'(1);
        phase_end = tick_end && (phase_q == ph_last);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tick_q  <= '0;
            phase_q <= '0;
            p_q     <= PW'(1);
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            e_q     <= 1'b0;
            oe_q    <= 1'b0;
            db_q    <= '0;
            rdata_q <= '0;
        end else begin
            read_q <= 1'b0;
            if (state_q == IDLE) begin
                if (valid_instr_i && phy_enable_i) begin
                    state_q <= SETUP;
                    read_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    rs_q    <= lcd_instr_i[DATA_WIDTH+1];
                    rw_q    <= lcd_instr_i[DATA_WIDTH];
                    oe_q    <= !lcd_instr_i[DATA_WIDTH];
                    db_q    <= lcd_instr_i[DATA_WIDTH-1:0];
                    p_q     <= p_d;
                    tick_q  <= '0;
                    phase_q <= '0;
                end
            end else if (!tick_end) begin
                tick_q <= tick_q + PW'(1);
            end else if (!phase_end) begin
                tick_q  <= '0;
                phase_q <= phase_q + PH_W'(1);
            end else begin
                tick_q  <= '0;
                phase_q <= '0;
                if (state_q == SETUP) begin
                    state_q <= EHIGH;
                    e_q     <= 1'b1;
                end else if (state_q == EHIGH) begin
                    state_q <= HOLD;
                    e_q     <= 1'b0;
                    if (rw_q) rdata_q <= lcd_db_i;
                end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    oe_q    <= 1'b0;
                end
            end
        end
    end

    assign phy_read_o  = read_q;
    assign busy_o      = busy_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = rw_q;
    assign lcd_e_o     = e_q;
    assign lcd_db_oe_o = oe_q;
    assign lcd_db_o    = db_q;
    assign lcd_rdata_o = rdata_q;
endmodule

// File: tb/tb_lcd_phy.sv
// tb_lcd_phy: directed checks of lcd_phy timing, read capture, back-to-back
// acceptance, prescaler shadowing and asynchronous reset.
module tb_lcd_phy;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] presc = 16'd2;
    logic [9:0]  instr = '0;
    logic        valid = 1'b0;
    logic        rd, busy, rs, rw, e, oe;
    logic [7:0]  rdata, db_o, db_i = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    lcd_phy dut (
        .clk_i(clk), .rst_i(rst), .phy_enable_i(en), .prescaler_10ns_i(presc),
        .lcd_instr_i(instr), .valid_instr_i(valid), .phy_read_o(rd),
        .lcd_rdata_o(rdata), .busy_o(busy), .lcd_rs_o(rs), .lcd_rw_o(rw),
        .lcd_e_o(e), .lcd_db_o(db_o), .lcd_db_oe_o(oe), .lcd_db_i(db_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " read"}, 32'(rd), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " e"}, 32'(e), 0);
        chk({tag, " rs"}, 32'(rs), 0);
        chk({tag, " rw"}, 32'(rw), 0);
        chk({tag, " oe"}, 32'(oe), 0);
        chk({tag, " db"}, 32'(db_o), 0);
        chk({tag, " rdata"}, 32'(rdata), 0);
    endtask

    // One transaction from IDLE with effective prescaler p: 6p busy cycles, E high in cycles p+1..4p.
    task automatic txn(input logic [9:0] ins, input logic [15:0] pr, input int p,
                       input logic [7:0] dbi, input logic [7:0] rd_before);
        instr = ins; presc = pr; db_i = dbi; valid = 1'b1;
        for (int i = 1; i <= 6 * p + 1; i++) begin
            @(posedge clk); #1;
            valid = 1'b0;
            chk("txn read", 32'(rd), 32'(i == 1));
            chk("txn busy", 32'(busy), 32'(i <= 6 * p));
            chk("txn e", 32'(e), 32'(i > p && i <= 4 * p));
            chk("txn oe", 32'(oe), 32'(i <= 6 * p && !ins[8]));
            chk("txn rs", 32'(rs), 32'(ins[9]));
            chk("txn rw", 32'(rw), 32'(ins[8]));
            if (!ins[8]) chk("txn db", 32'(db_o), 32'(ins[7:0]));
            chk("txn rdata", 32'(rdata), 32'((ins[8] && i > 4 * p) ? dbi : rd_before));
        end
    endtask

    initial begin
        #2;
        all_zero("reset");
        @(posedge clk); #1;
        all_zero("reset held");
        rst = 1'b0;
        en  = 1'b1;
        txn(10'h238, 16'd2, 2, 8'h00, 8'h00);
        txn(10'h100, 16'd0, 1, 8'hA5, 8'h00);
        txn(10'h0C1, 16'd1, 1, 8'h5A, 8'hA5);
        // valid held high: accepts at cycles 1, 8, 15 for a 6-cycle transaction
        instr = 10'h041; presc = 16'd1; valid = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            @(posedge clk); #1;
            chk("b2b read", 32'(rd), 32'(i == 1 || i == 8 || i == 15));
            if (i >= 22) chk("stall busy", 32'(busy), 0);
            if (i == 21) en = 1'b0;
        end
        valid = 1'b0;
        en = 1'b1;
        // prescaler change and enable drop mid-transaction keep P = 2
        instr = 10'h238; presc = 16'd2; valid = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(posedge clk); #1;
            valid = 1'b0;
            chk("shadow read", 32'(rd), 32'(i == 1));
            chk("shadow e", 32'(e), 32'(i > 2 && i <= 8));
            chk("shadow busy", 32'(busy), 32'(i <= 12));
            if (i == 2) presc = 16'd5;
            if (i == 4) en = 1'b0;
        end
        en = 1'b1;
        txn(10'h238, 16'd5, 5, 8'h00, 8'hA5);
        // asynchronous reset in the middle of a read's E-high phase
        instr = 10'h3AA; presc = 16'd2; db_i = 8'h77; valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            valid = 1'b0;
        end
        chk("pre-rst e", 32'(e), 1);
        #2 rst = 1'b1;
        #1 all_zero("async rst");
        instr = 10'h255; presc = 16'd1; valid = 1'b1;
        @(posedge clk); #1;
        all_zero("rst edge");
        rst = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        chk("post-rst read", 32'(rd), 1);
        chk("post-rst busy", 32'(busy), 1);
        chk("post-rst db", 32'(db_o), 32'h55);
        chk("post-rst rs", 32'(rs), 1);
        repeat (7) @(posedge clk);
        #1 chk("post-rst idle", 32'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
